mux8_rr_arbiter: RTL

MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

---
 rtl/mux8_rr_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter
// Round-robin arbiter for an 8-input registered mux. It picks one requester,
// drives the mux select, waits one cycle for the mux register to load, then
// presents out_valid until the downstream accepts. The pointer advances only
// on a completed transfer, so each requester is served in turn.
module mux8_rr_arbiter #(
   parameter int BACK2BACK = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] req,
   input  logic       out_ready,
   output logic [2:0] select,
   output logic [7:0] grant,
   output logic       out_valid,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      VALID = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [2:0] select_q, select_d;
   logic [7:0] grant_q, grant_d;
   logic       out_valid_q, out_valid_d;

   // Arbitration inputs: where the search starts and which requests count.
   logic [2:0] search_base;
   logic [7:0] search_vec;
   // Requests rotated so that bit 0 is the highest-priority index.
   logic [7:0] rot_vec;
   logic [2:0] win_off;
   logic [2:0] win_idx;
   logic [7:0] win_onehot;
   logic       win_any;

   // Pick search origin and request set: on completion the search starts
   // just after the finishing owner with its own request masked out.
   always_comb begin
      search_base = ptr_q;
      search_vec  = req;
      if (state_q == VALID) begin
         search_base = select_q + 3'd1;
         search_vec  = req & ~grant_q;
      end
   end

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_rotate
         assign rot_vec[gi] = search_vec[search_base + 3'(gi)];
      end
   endgenerate

   // Lowest set bit of the rotated vector is the offset of the winner.
   always_comb begin
      win_off = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (rot_vec[k]) begin
            win_off = 3'(k);
         end
      end
   end

   assign win_any = |search_vec;
   assign win_idx = search_base + win_off;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_decode
         assign win_onehot[gi] = (win_idx == 3'(gi));
      end
   endgenerate

   // Next-state and registered-output logic for the IDLE/LOAD/VALID FSM.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      select_d    = select_q;
      grant_d     = grant_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            grant_d     = 8'd0;
            out_valid_d = 1'b0;
            if (win_any) begin
               state_d  = LOAD;
               select_d = win_idx;
               grant_d  = win_onehot;
            end
         end
         LOAD: begin
            // Mux register captures the selected input during this cycle.
            state_d     = VALID;
            out_valid_d = 1'b1;
         end
         VALID: begin
            if (out_ready) begin
               ptr_d       = select_q + 3'd1;
               out_valid_d = 1'b0;
               if ((BACK2BACK != 0) && win_any) begin
                  state_d  = LOAD;
                  select_d = win_idx;
                  grant_d  = win_onehot;
               end else begin
                  state_d = IDLE;
                  grant_d = 8'd0;
               end
            end
         end
         default: begin
            state_d     = IDLE;
            grant_d     = 8'd0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset discards any transfer in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= 3'd0;
         select_q    <= 3'd0;
         grant_q     <= 8'd0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         select_q    <= select_d;
         grant_q     <= grant_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign select    = select_q;
   assign grant     = grant_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q != IDLE);

endmodule
